// File: rtl/bird_physics_if.sv
// Control inputs and sprite/state outputs between the Flappy-VGA game logic and bird_physics.
// The master drives frame strobe, game control and buttons; the slave returns bird geometry and state.
interface bird_physics_if #(
  parameter int W = 10
);
  logic              Tick;
  logic              Start;
  logic              Stop;
  logic              Ack;
  logic              BtnU;
  logic              BtnD;
  logic [W-1:0]      Bird_X_L;
  logic [W-1:0]      Bird_X_R;
  logic [W-1:0]      Bird_Y_T;
  logic [W-1:0]      Bird_Y_B;
  logic signed [7:0] VertSpeed;
  logic              HitCeil;
  logic              HitFloor;
  logic              q_Initial;
  logic              q_Flight;
  logic              q_Stop;

  modport master (
    output Tick, Start, Stop, Ack, BtnU, BtnD,
    input  Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B, VertSpeed,
    input  HitCeil, HitFloor, q_Initial, q_Flight, q_Stop
  );

  modport slave (
    input  Tick, Start, Stop, Ack, BtnU, BtnD,
    output Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B, VertSpeed,
    output HitCeil, HitFloor, q_Initial, q_Flight, q_Stop
  );
endinterface

// File: rtl/bird_physics.sv
// Vertical motion of the Flappy-VGA bird sprite, advanced once per frame Tick.
// Define FLAPPY_GRAVITY_EN for gravity/flap physics; otherwise BtnU/BtnD step the bird manually.
module bird_physics #(
  parameter int W       = 10,
  parameter int BIRD_X0 = 230,
  parameter int BIRD_Y0 = 220,
  parameter int BIRD_W  = 40,
  parameter int BIRD_H  = 25,
  parameter int MIN_Y   = 4,
  parameter int MAX_Y   = 639,
  parameter int JUMP_V  = 8,
  parameter int GRAVITY = 1,
  parameter int VMAX    = 12,
  parameter int STEP    = 4
) (
  input  logic          Clk,
  input  logic          reset,
  bird_physics_if.slave bus
);
  // Two extra bits let the candidate position go negative or past the screen without wrapping.
  localparam int YW = W + 2;
  localparam logic signed [YW-1:0] MIN_Y_S = YW'(MIN_Y);
  localparam logic [W-1:0]         Y0      = W'(BIRD_Y0);
  localparam logic [W-1:0]         H_M1    = W'(BIRD_H - 1);

  if (VMAX > 127 || JUMP_V > 128 || STEP > 127 || GRAVITY < 0 || GRAVITY > 127) begin : g_bad_cfg
    $error("bird_physics: velocity parameters do not fit the 8-bit VertSpeed");
  end

  typedef enum logic [2:0] {
    S_INIT   = 3'b001,
    S_FLIGHT = 3'b010,
    S_STOP   = 3'b100
  } state_t;

  state_t            state;
  logic [W-1:0]      y_t;
  logic [W-1:0]      y_b;
  logic signed [7:0] vel;
  logic              hit_ceil;
  logic              hit_floor;

  logic signed [YW-1:0] y_ext_p0;
  logic [W-1:0]         y_new_p0;
  logic signed [7:0]    v_new_p0;
  logic                 ceil_p0;
  logic                 floor_p0;

  assign y_ext_p0 = $signed({2'b00, y_t});

`ifdef FLAPPY_GRAVITY_EN
  localparam logic signed [YW-1:0] FLOOR_T_S = YW'(MAX_Y - BIRD_H + 1);
  localparam logic signed [7:0]    JUMP_V_S  = 8'(-JUMP_V);

  logic                 flap_pend;
  logic                 btn_q;
  logic                 flap_edge;
  logic signed [7:0]    v_try_p0;
  logic signed [YW-1:0] y_try_p0;

  assign flap_edge = bus.BtnU & ~btn_q;

  function automatic logic signed [7:0] grav_sat(input logic signed [7:0] v);
    logic signed [9:0] s;
    s = 10'(v) + 10'(GRAVITY);
    return (s > 10'(VMAX)) ? 8'(VMAX) : s[7:0];
  endfunction

  // Stage p0: semi-implicit update, new velocity first, then position from it.
  always_comb begin
    v_try_p0 = (flap_pend | flap_edge) ? JUMP_V_S : grav_sat(vel);
    y_try_p0 = y_ext_p0 + YW'(v_try_p0);
    ceil_p0  = (y_try_p0 < MIN_Y_S);
    floor_p0 = !ceil_p0 && (y_try_p0 > FLOOR_T_S);
    y_new_p0 = ceil_p0  ? W'(MIN_Y) :
               floor_p0 ? W'(FLOOR_T_S) : y_try_p0[W-1:0];
    v_new_p0 = (ceil_p0 | floor_p0) ? 8'sd0 : v_try_p0;
  end
`else
  localparam logic signed [YW-1:0] STEP_S     = YW'(STEP);
  localparam logic signed [YW-1:0] MAX_Y_S    = YW'(MAX_Y);
  localparam logic signed [YW-1:0] DN_REACH_S = YW'(BIRD_H - 1 + STEP);

  // Stage p0: a move is taken only if the whole step stays on screen.
  always_comb begin
    ceil_p0  = 1'b0;
    floor_p0 = 1'b0;
    y_new_p0 = y_t;
    v_new_p0 = 8'sd0;
    if (bus.BtnU && (y_ext_p0 - STEP_S >= MIN_Y_S)) begin
      y_new_p0 = y_t - W'(STEP);
      v_new_p0 = 8'(-STEP);
    end else if (bus.BtnD && (y_ext_p0 + DN_REACH_S <= MAX_Y_S)) begin
      y_new_p0 = y_t + W'(STEP);
      v_new_p0 = 8'(STEP);
    end
  end
`endif

  // Stage p1: registered state, position, velocity and clamp pulses.
  always_ff @(posedge Clk) begin
    hit_ceil  <= 1'b0;
    hit_floor <= 1'b0;
    if (reset) begin
      state <= S_INIT;
      y_t   <= Y0;
      y_b   <= Y0 + H_M1;
      vel   <= '0;
`ifdef FLAPPY_GRAVITY_EN
      flap_pend <= 1'b0;
      btn_q     <= 1'b0;
`endif
    end else begin
`ifdef FLAPPY_GRAVITY_EN
      btn_q <= bus.BtnU;
`endif
      case (state)
        S_INIT: begin
          y_t <= Y0;
          y_b <= Y0 + H_M1;
          vel <= '0;
`ifdef FLAPPY_GRAVITY_EN
          flap_pend <= 1'b0;
`endif
          if (bus.Start) state <= S_FLIGHT;
        end
        S_FLIGHT: begin
          if (bus.Stop) begin
            state <= S_STOP;
          end else if (bus.Tick) begin
            y_t       <= y_new_p0;
            y_b       <= y_new_p0 + H_M1;
            vel       <= v_new_p0;
            hit_ceil  <= ceil_p0;
            hit_floor <= floor_p0;
`ifdef FLAPPY_GRAVITY_EN
            flap_pend <= 1'b0;
          end else if (flap_edge) begin
            flap_pend <= 1'b1;
`endif
          end
        end
        S_STOP: begin
          if (bus.Ack) state <= S_INIT;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.Bird_X_L  = W'(BIRD_X0);
  assign bus.Bird_X_R  = W'(BIRD_X0 + BIRD_W - 1);
  assign bus.Bird_Y_T  = y_t;
  assign bus.Bird_Y_B  = y_b;
  assign bus.VertSpeed = vel;
  assign bus.HitCeil   = hit_ceil;
  assign bus.HitFloor  = hit_floor;
  assign bus.q_Initial = state[0];
  assign bus.q_Flight  = state[1];
  assign bus.q_Stop    = state[2];
endmodule

// File: tb/tb_bird_physics.sv
// Bench for bird_physics: constant vector table, corner sequences and random stimulus vs. a cycle model.
// Follows the DUT build: FLAPPY_GRAVITY_EN selects physics expectations, otherwise manual mode.
module tb_bird_physics;
  localparam int X0 = 230, BW = 40, Y0 = 220, BH = 25, MINY = 4, MAXY = 639;
  localparam int JV = 8, GR = 1, VM = 12, ST = 4;

  logic Clk;
  logic reset;
  bird_physics_if #(.W(10)) bus();

  bird_physics dut (.Clk(Clk), .reset(reset), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit       rst, tick, start, stop, ack, bu, bd;
    int       yt, v;
    bit [2:0] q;
  } vec_t;
  vec_t vecs[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: state 0=Initial 1=Flight 2=Stop, plain integer position/velocity.
  int m_st, m_y, m_v;
  bit m_hc, m_hf;
`ifdef FLAPPY_GRAVITY_EN
  bit m_pend, m_prev;
`endif

  function automatic vec_t mk(input bit r, tk, sa, so, ak, bu, bd, input int yt, v, input bit [2:0] q);
    vec_t t;
    t.rst = r; t.tick = tk; t.start = sa; t.stop = so; t.ack = ak; t.bu = bu; t.bd = bd;
    t.yt = yt; t.v = v; t.q = q;
    return t;
  endfunction

  function automatic logic [2:0] dut_q();
    return {bus.q_Stop, bus.q_Flight, bus.q_Initial};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_cycle(input bit r, tk, sa, so, ak, bu, bd);
`ifdef FLAPPY_GRAVITY_EN
    int nv, ny;
    bit flap;
`endif
    m_hc = 0;
    m_hf = 0;
    if (r) begin
      m_st = 0; m_y = Y0; m_v = 0;
`ifdef FLAPPY_GRAVITY_EN
      m_pend = 0;
`endif
    end else if (m_st == 0) begin
      m_y = Y0; m_v = 0;
`ifdef FLAPPY_GRAVITY_EN
      m_pend = 0;
`endif
      if (sa) m_st = 1;
    end else if (m_st == 1) begin
      if (so) begin
        m_st = 2;
      end else if (tk) begin
`ifdef FLAPPY_GRAVITY_EN
        flap = m_pend || (bu && !m_prev);
        nv = flap ? -JV : ((m_v + GR > VM) ? VM : m_v + GR);
        ny = m_y + nv;
        if (ny < MINY)               begin m_y = MINY;          m_v = 0; m_hc = 1; end
        else if (ny + BH - 1 > MAXY) begin m_y = MAXY - BH + 1; m_v = 0; m_hf = 1; end
        else                         begin m_y = ny;            m_v = nv; end
        m_pend = 0;
`else
        if (bu && m_y - ST >= MINY)               begin m_y = m_y - ST; m_v = -ST; end
        else if (bd && m_y + BH - 1 + ST <= MAXY) begin m_y = m_y + ST; m_v = ST; end
        else m_v = 0;
`endif
      end
`ifdef FLAPPY_GRAVITY_EN
      else if (bu && !m_prev) m_pend = 1;
`endif
    end else begin
      if (ak) m_st = 0;
    end
`ifdef FLAPPY_GRAVITY_EN
    m_prev = r ? 1'b0 : bu;
`endif
  endtask

  task automatic check_model();
    chk("model_y_t", int'(bus.Bird_Y_T), m_y);
    chk("model_y_b", int'(bus.Bird_Y_B), m_y + BH - 1);
    chk("model_vel", int'(bus.VertSpeed), m_v);
    chk("model_state", int'(dut_q()), (m_st == 0) ? 1 : (m_st == 1) ? 2 : 4);
    chk("model_hit_ceil", int'(bus.HitCeil), int'(m_hc));
    chk("model_hit_floor", int'(bus.HitFloor), int'(m_hf));
    chk("x_left", int'(bus.Bird_X_L), X0);
    chk("x_right", int'(bus.Bird_X_R), X0 + BW - 1);
  endtask

  task automatic step(input bit r, tk, sa, so, ak, bu, bd);
    @(negedge Clk);
    reset = r; bus.Tick = tk; bus.Start = sa; bus.Stop = so; bus.Ack = ak;
    bus.BtnU = bu; bus.BtnD = bd;
    @(posedge Clk);
    model_cycle(r, tk, sa, so, ak, bu, bd);
    #1;
    check_model();
  endtask

  task automatic reset_mid_flight();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
`ifdef FLAPPY_GRAVITY_EN
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    chk("pre_reset_y_t", int'(bus.Bird_Y_T), 226);
`else
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 1);
    chk("pre_reset_y_t", int'(bus.Bird_Y_T), 300);
`endif
    step(1, 0, 0, 0, 0, 0, 0);
    chk("mid_reset_y_t", int'(bus.Bird_Y_T), 220);
    chk("mid_reset_vel", int'(bus.VertSpeed), 0);
    chk("mid_reset_state", int'(dut_q()), 3'b001);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("stop_state", int'(dut_q()), 3'b100);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("ack_state", int'(dut_q()), 3'b001);
  endtask

`ifdef FLAPPY_GRAVITY_EN
  task automatic seq_floor();
    bit seen;
    seen = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 60 && !seen; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      chk("vel_within_vmax", int'(int'(bus.VertSpeed) <= VM), 1);
      if (i == 11) chk("vel_terminal", int'(bus.VertSpeed), VM);
      if (bus.HitFloor) seen = 1;
    end
    chk("floor_reached", int'(seen), 1);
    chk("floor_y_t", int'(bus.Bird_Y_T), 615);
    chk("floor_y_b", int'(bus.Bird_Y_B), 639);
    chk("floor_vel", int'(bus.VertSpeed), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("floor_pulse_len", int'(bus.HitFloor), 0);
  endtask

  task automatic seq_ceil();
    bit seen;
    seen = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0, 1, 0, 0, 0, 1, 0);
      if (bus.HitCeil) seen = 1;
      else step(0, 0, 0, 0, 0, 0, 0);
    end
    chk("ceil_reached", int'(seen), 1);
    chk("ceil_y_t", int'(bus.Bird_Y_T), 4);
    chk("ceil_vel", int'(bus.VertSpeed), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("ceil_pulse_len", int'(bus.HitCeil), 0);
    step(0, 1, 0, 1, 0, 1, 0);
    chk("stop_beats_tick_state", int'(dut_q()), 3'b100);
    chk("stop_beats_tick_y_t", int'(bus.Bird_Y_T), 4);
  endtask
`else
  task automatic seq_edges();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 80 && bus.Bird_Y_T != 10'd4; i++) step(0, 1, 0, 0, 0, 1, 0);
    chk("man_top_y_t", int'(bus.Bird_Y_T), 4);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("man_top_hold", int'(bus.Bird_Y_T), 4);
    chk("man_top_vel", int'(bus.VertSpeed), 0);
    chk("man_top_no_hit", int'(bus.HitCeil), 0);
    for (int i = 0; i < 200 && bus.Bird_Y_B != 10'd636; i++) step(0, 1, 0, 0, 0, 0, 1);
    chk("man_bot_y_b", int'(bus.Bird_Y_B), 636);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("man_bot_hold", int'(bus.Bird_Y_B), 636);
    chk("man_bot_vel", int'(bus.VertSpeed), 0);
    chk("man_bot_no_hit", int'(bus.HitFloor), 0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.Tick = 0; bus.Start = 0; bus.Stop = 0; bus.Ack = 0; bus.BtnU = 0; bus.BtnD = 0;

`ifdef FLAPPY_GRAVITY_EN
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 220,  0, 3'b001));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 220,  0, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 221,  1, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 223,  2, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 215, -8, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 208, -7, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 208, -7, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 208, -7, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 208, -7, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 200, -8, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 193, -7, 3'b010));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 193, -7, 3'b100));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 193, -7, 3'b001));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 220,  0, 3'b001));
`else
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 220,  0, 3'b001));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 220,  0, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 216, -4, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 212, -4, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 208, -4, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 208, -4, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 212,  4, 3'b010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 212,  0, 3'b010));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 212,  0, 3'b100));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 212,  0, 3'b100));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 212,  0, 3'b001));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 220,  0, 3'b001));
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].start, vecs[i].stop, vecs[i].ack, vecs[i].bu, vecs[i].bd);
      chk($sformatf("vec%0d_y_t", i), int'(bus.Bird_Y_T), vecs[i].yt);
      chk($sformatf("vec%0d_y_b", i), int'(bus.Bird_Y_B), vecs[i].yt + 24);
      chk($sformatf("vec%0d_vel", i), int'(bus.VertSpeed), vecs[i].v);
      chk($sformatf("vec%0d_state", i), int'(dut_q()), int'(vecs[i].q));
      chk($sformatf("vec%0d_hits", i), int'({bus.HitCeil, bus.HitFloor}), 0);
    end

`ifdef FLAPPY_GRAVITY_EN
    seq_floor();
    seq_ceil();
`else
    seq_edges();
`endif
    reset_mid_flight();

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
